l2_block_serializer: RTL

Memory-side stage directly downstream of the coherence bus controller. It accepts one block-wide L2 read or write request from the bus controller and splits it into BLOCK_SIZE_WORDS single-word accesses on a generic word bus with wait states. Read words are assembled back into a block, and completion or timeout is reported on the l2state handshake. The bus controller's L2 port therefore sees one block transaction, while the backing memory sees only word traffic.

---
 rtl/l2_block_serializer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/l2_block_serializer.sv
// l2_block_serializer: splits one block-wide L2 read/write into
// BLOCK_SIZE_WORDS word accesses on a wait-state word bus.
// Ports:
//   CLK, RST            clock, async active-high reset
//   l2REN/l2WEN/l2addr  block request from the bus controller
//   l2store/l2load      write block in, assembled read block out
//   l2state             FREE/BUSY/ACCESS/ERROR handshake
//   mem_*               word bus (strobe accepted when mem_busy=0)
module l2_block_serializer #(
    parameter int BLOCK_SIZE_WORDS = 2,
    parameter int WORD_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               l2REN,
    input  logic                               l2WEN,
    input  logic [ADDR_W-1:0]                  l2addr,
    input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2store,
    output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2load,
    output logic [1:0]                         l2state,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [WORD_W-1:0]                  mem_wdata,
    input  logic [WORD_W-1:0]                  mem_rdata,
    output logic                               mem_ren,
    output logic                               mem_wen,
    output logic [3:0]                         mem_byte_en,
    input  logic                               mem_busy
);

    localparam int BLK_W  = BLOCK_SIZE_WORDS * WORD_W;
    localparam int IDX_W  = $clog2(BLOCK_SIZE_WORDS);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OFF_W  = $clog2(BLOCK_SIZE_WORDS * 4);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_SIZE_WORDS - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] L2_FREE   = 2'd0;
    localparam logic [1:0] L2_BUSY   = 2'd1;
    localparam logic [1:0] L2_ACCESS = 2'd2;
    localparam logic [1:0] L2_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BLK_W-1:0]    store_q, store_d;
    logic                op_wr_q, op_wr_d;
    logic [BLK_W-1:0]    load_q, load_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          l2state_q, l2state_d;
    logic                xfer_d;

    // Block-offset address bits are discarded by the alignment.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ^l2addr[OFF_W-1:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        base_d  = base_q;
        store_d = store_q;
        op_wr_d = op_wr_q;
        load_d  = load_q;

        unique case (state_q)
            IDLE: begin
                idx_d  = '0;
                wait_d = '0;
                if (l2REN || l2WEN) begin
                    base_d  = {l2addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    store_d = l2store;
                    op_wr_d = l2WEN;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!mem_busy) begin
                    if (!op_wr_q) begin
                        load_d[idx_q*WORD_W +: WORD_W] = mem_rdata;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        wait_d = '0;
                    end
                end else begin
                    // Saturating count of consecutive busy cycles.
                    if (wait_q != WAIT_MAX) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                    if (wait_d == WAIT_MAX) begin
                        state_d = ERR;
                    end
                end
            end
            DONE, ERR: begin
                if (!l2REN && !l2WEN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so the bus
    // sees the strobe one cycle after the request is sampled.
    always_comb begin
        xfer_d  = (state_d == XFER);
        ren_d   = xfer_d && !op_wr_d;
        wen_d   = xfer_d && op_wr_d;
        be_d    = xfer_d ? 4'hF : 4'h0;
        addr_d  = xfer_d ? (base_d | (ADDR_W'(idx_d) << 2)) : '0;
        wdata_d = wen_d ? store_d[idx_d*WORD_W +: WORD_W] : '0;
        l2state_d = L2_FREE;
        unique case (state_d)
            IDLE:    l2state_d = L2_FREE;
            XFER:    l2state_d = L2_BUSY;
            DONE:    l2state_d = L2_ACCESS;
            ERR:     l2state_d = L2_ERROR;
            default: l2state_d = L2_FREE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            base_q    <= '0;
            store_q   <= '0;
            op_wr_q   <= 1'b0;
            load_q    <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= '0;
            wdata_q   <= '0;
            l2state_q <= L2_FREE;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            base_q    <= base_d;
            store_q   <= store_d;
            op_wr_q   <= op_wr_d;
            load_q    <= load_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            l2state_q <= l2state_d;
        end
    end

    assign l2load      = load_q;
    assign l2state     = l2state_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_ren     = ren_q;
    assign mem_wen     = wen_q;
    assign mem_byte_en = be_q;

endmodule
